// File: rtl/wb_read_prefetch_buffer.sv
// Single-line read prefetch buffer between the SRAM wishbone arbiter and the SPI SRAM controller.
// Define WB_PREFETCH_WRITE_UPDATE_EN to have write hits patch the line instead of invalidating it.
module wb_read_prefetch_buffer #(
  parameter int ADDR_WIDTH = 23,
  parameter int LINE_BITS  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_dat_i,
  input  logic [2:0]            wbs_cti_i,
  input  logic [1:0]            wbs_bte_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [7:0]            wbs_dat_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic                  wbm_we_o,
  output logic [7:0]            wbm_dat_o,
  output logic [2:0]            wbm_cti_o,
  output logic [1:0]            wbm_bte_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  input  logic                  wbm_rty_i,
  input  logic [7:0]            wbm_dat_i,
  input  logic                  flush_i
);
  localparam int N  = 1 << LINE_BITS;
  localparam int TW = ADDR_WIDTH - LINE_BITS;
  localparam logic [LINE_BITS-1:0] LAST = '1;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {IDLE, RESP, FILL, WRITE} state_t;

  state_t                 state_q;
  logic [7:0]             line_q [N];
  logic                   valid_q;
  logic [TW-1:0]          tag_q, req_tag_q;
  logic [LINE_BITS-1:0]   req_off_q, beat_q;
  logic                   flush_pend_q, live_q, wr_hit_q;
  logic                   ack_q, err_q, rty_q;
  logic [7:0]             sdat_q, mdat_q;
  logic                   mcyc_q, mstb_q, mwe_q;
  logic [ADDR_WIDTH-1:0]  madr_q;
  logic [2:0]             mcti_q;

  logic                   req, hit;
  logic [TW-1:0]          req_tag;
  logic [LINE_BITS-1:0]   req_off, beat_d;
  logic                   unused_ok;

  assign req       = wbs_cyc_i && wbs_stb_i;
  assign req_tag   = wbs_adr_i[ADDR_WIDTH-1:LINE_BITS];
  assign req_off   = wbs_adr_i[LINE_BITS-1:0];
  // A flush in the same cycle as a request wins, so the request is treated as a miss.
  assign hit       = valid_q && !flush_i && (tag_q == req_tag);
  assign beat_d    = beat_q + 1'b1;
  assign unused_ok = ^{wbs_cti_i, wbs_bte_i};

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_rty_o = rty_q;
  assign wbs_dat_o = sdat_q;
  assign wbm_cyc_o = mcyc_q;
  assign wbm_stb_o = mstb_q;
  assign wbm_adr_o = madr_q;
  assign wbm_we_o  = mwe_q;
  assign wbm_dat_o = mdat_q;
  assign wbm_cti_o = mcti_q;
  assign wbm_bte_o = 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      req_tag_q    <= '0;
      req_off_q    <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      live_q       <= 1'b0;
      wr_hit_q     <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rty_q        <= 1'b0;
      sdat_q       <= '0;
      mdat_q       <= '0;
      mcyc_q       <= 1'b0;
      mstb_q       <= 1'b0;
      mwe_q        <= 1'b0;
      madr_q       <= '0;
      mcti_q       <= CTI_CLASSIC;
      for (int i = 0; i < N; i++) line_q[i] <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_i) valid_q <= 1'b0;
          if (req) begin
            req_tag_q <= req_tag;
            req_off_q <= req_off;
            if (wbs_we_i) begin
              state_q  <= WRITE;
              wr_hit_q <= hit;
              mcyc_q   <= 1'b1;
              mstb_q   <= 1'b1;
              mwe_q    <= 1'b1;
              madr_q   <= wbs_adr_i;
              mdat_q   <= wbs_dat_i;
              mcti_q   <= CTI_CLASSIC;
            end else if (hit) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
              sdat_q  <= line_q[req_off];
            end else begin
              state_q      <= FILL;
              beat_q       <= '0;
              live_q       <= 1'b1;
              flush_pend_q <= 1'b0;
              mcyc_q       <= 1'b1;
              mstb_q       <= 1'b1;
              mwe_q        <= 1'b0;
              madr_q       <= {req_tag, {LINE_BITS{1'b0}}};
              mcti_q       <= CTI_INCR;
            end
          end
        end
        RESP: begin
          if (flush_i) valid_q <= 1'b0;
          state_q <= IDLE;
        end
        FILL: begin
          // The SPI side cannot abort, so a departed master only suppresses the response.
          if (flush_i) flush_pend_q <= 1'b1;
          live_q <= live_q && wbs_cyc_i;
          if (wbm_ack_i) begin
            line_q[beat_q] <= wbm_dat_i;
            if (beat_q == LAST) begin
              state_q <= RESP;
              mcyc_q  <= 1'b0;
              mstb_q  <= 1'b0;
              mcti_q  <= CTI_CLASSIC;
              tag_q   <= req_tag_q;
              valid_q <= !(flush_pend_q || flush_i);
              ack_q   <= live_q && wbs_cyc_i;
              sdat_q  <= (req_off_q == LAST) ? wbm_dat_i : line_q[req_off_q];
            end else begin
              beat_q <= beat_d;
              madr_q <= {req_tag_q, beat_d};
              mcti_q <= (beat_d == LAST) ? CTI_END : CTI_INCR;
            end
          end else if (wbm_err_i || wbm_rty_i) begin
            state_q <= RESP;
            mcyc_q  <= 1'b0;
            mstb_q  <= 1'b0;
            mcti_q  <= CTI_CLASSIC;
            valid_q <= 1'b0;
            err_q   <= live_q && wbs_cyc_i && wbm_err_i;
            rty_q   <= live_q && wbs_cyc_i && !wbm_err_i;
          end
        end
        WRITE: begin
          if (flush_i) valid_q <= 1'b0;
          if (wbm_ack_i || wbm_err_i || wbm_rty_i) begin
            state_q <= RESP;
            mcyc_q  <= 1'b0;
            mstb_q  <= 1'b0;
            mwe_q   <= 1'b0;
            ack_q   <= wbm_ack_i;
            err_q   <= !wbm_ack_i && wbm_err_i;
            rty_q   <= !wbm_ack_i && !wbm_err_i;
          end
          if (wbm_ack_i && wr_hit_q) begin
`ifdef WB_PREFETCH_WRITE_UPDATE_EN
            line_q[req_off_q] <= mdat_q;
`else
            valid_q <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
